// File: rtl/osc_pkg.sv
// Shared definitions for the oscillator output path: DAC frame geometry,
// the default DAC command nibble and the SPI transmitter state encoding.
package osc_pkg;

  localparam int DAC_FRAME_BITS  = 16;
  localparam int DAC_SAMPLE_BITS = 12;
  localparam logic [3:0] DAC_CMD = 4'b0011;  // A/B=0, BUF=0, GA_n=1, SHDN_n=1

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CS_HIGH,
    LATCH
  } dac_state_e;

  // Full DAC word as it leaves the shift register, MSB first.
  function automatic logic [DAC_FRAME_BITS-1:0] dac_frame(
    input logic [3:0]                 cmd,
    input logic [DAC_SAMPLE_BITS-1:0] sample
  );
    return {cmd, sample};
  endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample handshake between a waveform generator and the DAC transmitter.
interface dac_spi_tx_if;
  import osc_pkg::*;

  logic [DAC_SAMPLE_BITS-1:0] sample_in;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/dac_spi_tx_phase_timer.sv
// Phase timer for the DAC transmitter: counts CLK_DIV cycles from the last
// restart and flags the final cycle (phase_done_o) and the one before it
// (phase_near_o, never asserted when CLK_DIV is 1).
module spi_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic phase_done_o,
  output logic phase_near_o
);

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign phase_done_o = (cnt_q == LAST_CNT);

  generate
    if (CLK_DIV >= 2) begin : g_near
      localparam logic [7:0] NEAR_CNT = 8'(CLK_DIV - 2);
      assign phase_near_o = (cnt_q == NEAR_CNT);
    end else begin : g_no_near
      assign phase_near_o = 1'b0;
    end
  endgenerate

  // Count up, wrapping at the end of each phase or on an explicit restart.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart_i || phase_done_o) begin
      cnt_d = 8'd0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 12-bit waveform samples into 16-bit MCP4921-style SPI frames
// (command nibble + sample, MSB first) and pulses LDAC after every frame.
module dac_spi_tx
  import osc_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter logic [3:0] CMD_BITS = DAC_CMD
) (
  input  logic        clk,
  input  logic        rst_n,
  dac_spi_tx_if.slave s_if,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_ldac_n
);

  localparam logic [4:0] LAST_BIT = 5'(DAC_FRAME_BITS - 1);

  dac_state_e                state_q, state_d;
  logic [DAC_FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]                bitcnt_q, bitcnt_d;
  logic                      phase_hi_q, phase_hi_d;
  logic                      cs_n_q, cs_n_d;
  logic                      sclk_q, sclk_d;
  logic                      mosi_q, mosi_d;
  logic                      ldac_n_q, ldac_n_d;
  logic                      ready_q, ready_d;
  logic                      accept;
  logic                      restart;
  logic                      phase_done;
  logic                      phase_near;
  logic [DAC_FRAME_BITS-1:0] frame;

  spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart_i    (restart),
    .phase_done_o (phase_done),
    .phase_near_o (phase_near)
  );

  // ready_q is only ever high in IDLE or in the last LATCH cycle, so any
  // handshake is a frame load.
  assign accept = s_if.sample_valid && ready_q;
  assign frame  = dac_frame(CMD_BITS, s_if.sample_in);

  // Next-state and output decode. Ready is raised one cycle before LATCH
  // ends so that the registered ready lets the next sample in on the very
  // edge that closes the frame (period stays at 34 phases).
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    phase_hi_d = phase_hi_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ldac_n_d   = ldac_n_q;
    ready_d    = ready_q;
    restart    = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
      end
      SHIFT: begin
        if (phase_done) begin
          restart = 1'b1;
          if (!phase_hi_q) begin
            sclk_d     = 1'b1;
            phase_hi_d = 1'b1;
          end else begin
            sclk_d     = 1'b0;
            phase_hi_d = 1'b0;
            if (bitcnt_q == LAST_BIT) begin
              state_d  = CS_HIGH;
              cs_n_d   = 1'b1;
              bitcnt_d = 5'd0;
            end else begin
              // Rotate rather than shift so the register never holds dead bits.
              bitcnt_d = bitcnt_q + 5'd1;
              shreg_d  = {shreg_q[DAC_FRAME_BITS-2:0], shreg_q[DAC_FRAME_BITS-1]};
              mosi_d   = shreg_q[DAC_FRAME_BITS-2];
            end
          end
        end
      end
      CS_HIGH: begin
        if (phase_done) begin
          restart  = 1'b1;
          state_d  = LATCH;
          ldac_n_d = 1'b0;
          if (CLK_DIV == 1) begin
            ready_d = 1'b1;
          end
        end
      end
      LATCH: begin
        if (phase_near) begin
          ready_d = 1'b1;
        end
        if (phase_done) begin
          restart  = 1'b1;
          ldac_n_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d    = SHIFT;
      shreg_d    = frame;
      mosi_d     = frame[DAC_FRAME_BITS-1];
      bitcnt_d   = 5'd0;
      phase_hi_d = 1'b0;
      cs_n_d     = 1'b0;
      sclk_d     = 1'b0;
      ready_d    = 1'b0;
      restart    = 1'b1;
    end
  end

  // State, data and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= 5'd0;
      phase_hi_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ldac_n_q   <= 1'b1;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      phase_hi_q <= phase_hi_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ldac_n_q   <= ldac_n_d;
      ready_q    <= ready_d;
    end
  end

  assign s_if.sample_ready = ready_q;
  assign dac_cs_n          = cs_n_q;
  assign dac_sclk          = sclk_q;
  assign dac_mosi          = mosi_q;
  assign dac_ldac_n        = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV=4 default command, and
// CLK_DIV=1 with command 4'b0111). Stimulus pushes expected words into a
// per-instance queue; an SPI monitor reassembles frames and checks timing.
module tb_dac_spi_tx;

  localparam int         CDIV_A = 4;
  localparam logic [3:0] CMD_A  = 4'b0011;
  localparam int         CDIV_B = 1;
  localparam logic [3:0] CMD_B  = 4'b0111;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic cs_a, sclk_a, mosi_a, ldac_a;
  logic cs_b, sclk_b, mosi_b, ldac_b;

  dac_spi_tx_if if_a ();
  dac_spi_tx_if if_b ();

  dac_spi_tx #(.CLK_DIV(CDIV_A), .CMD_BITS(CMD_A)) dut_a (
    .clk(clk), .rst_n(rst_a), .s_if(if_a),
    .dac_cs_n(cs_a), .dac_sclk(sclk_a), .dac_mosi(mosi_a), .dac_ldac_n(ldac_a)
  );

  dac_spi_tx #(.CLK_DIV(CDIV_B), .CMD_BITS(CMD_B)) dut_b (
    .clk(clk), .rst_n(rst_b), .s_if(if_b),
    .dac_cs_n(cs_b), .dac_sclk(sclk_b), .dac_mosi(mosi_b), .dac_ldac_n(ldac_b)
  );

  always #5 clk = ~clk;

  logic [1:0] rst_w, cs_w, sclk_w, mosi_w, ldac_w, ready_w;
  assign rst_w   = {rst_b, rst_a};
  assign cs_w    = {cs_b, cs_a};
  assign sclk_w  = {sclk_b, sclk_a};
  assign mosi_w  = {mosi_b, mosi_a};
  assign ldac_w  = {ldac_b, ldac_a};
  assign ready_w = {if_b.sample_ready, if_a.sample_ready};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] cap_log[$];

  // Monitor state, one slot per instance.
  int          e0[2], bits[2], last_rise[2], mchg[2], cs_rise[2], gap_last[2];
  int          frames_started[2], frames_done[2];
  logic [15:0] word[2];
  bit          tok[2], in_fr[2], have_e0[2];
  logic [1:0]  prev_cs, prev_sclk, prev_mosi, prev_ldac;

  function automatic int cdiv(input int idx);
    return (idx == 0) ? CDIV_A : CDIV_B;
  endfunction

  function automatic void chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endfunction

  function automatic bit pop_exp(input int idx, output logic [15:0] w);
    w = '0;
    if (idx == 0) begin
      if (exp_q0.size() == 0) return 1'b0;
      w = exp_q0.pop_front();
    end else begin
      if (exp_q1.size() == 0) return 1'b0;
      w = exp_q1.pop_front();
    end
    return 1'b1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SPI monitor: sampled on the falling clk edge, away from DUT updates.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int          c;
      logic [15:0] w;
      bit          got;
      c = cdiv(i);
      if (!rst_w[i]) begin
        in_fr[i]   = 1'b0;
        have_e0[i] = 1'b0;
        bits[i]    = 0;
      end else begin
        if (have_e0[i]) begin
          if (cyc == e0[i] + 34 * c - 2) chk("ready_low_before_end", i, int'(ready_w[i]), 0);
          if (cyc == e0[i] + 34 * c - 1) chk("ready_high_at_end", i, int'(ready_w[i]), 1);
          if (prev_ldac[i] && !ldac_w[i]) chk("ldac_fall_offset", i, cyc - e0[i], 33 * c);
          if (!prev_ldac[i] && ldac_w[i]) chk("ldac_rise_offset", i, cyc - e0[i], 34 * c);
        end
        if (prev_cs[i] && !cs_w[i]) begin
          gap_last[i]  = cyc - cs_rise[i];
          e0[i]        = cyc;
          have_e0[i]   = 1'b1;
          in_fr[i]     = 1'b1;
          bits[i]      = 0;
          word[i]      = '0;
          tok[i]       = 1'b1;
          last_rise[i] = -1;
          mchg[i]      = cyc;
          frames_started[i]++;
        end else if (in_fr[i]) begin
          if (!prev_sclk[i] && sclk_w[i]) begin
            if (bits[i] == 0) tok[i] = tok[i] && (cyc == e0[i] + c);
            else              tok[i] = tok[i] && (cyc - last_rise[i] == 2 * c);
            tok[i]       = tok[i] && (cyc - mchg[i] >= c);
            word[i]      = {word[i][14:0], mosi_w[i]};
            bits[i]      = bits[i] + 1;
            last_rise[i] = cyc;
          end
          if (mosi_w[i] != prev_mosi[i]) begin
            if (last_rise[i] >= 0) tok[i] = tok[i] && (cyc - last_rise[i] >= c);
            mchg[i] = cyc;
          end
          if (cs_w[i]) begin
            chk("cs_low_cycles", i, cyc - e0[i], 32 * c);
            chk("sclk_rises", i, bits[i], 16);
            chk("spi_timing", i, int'(tok[i]), 1);
            chk("sclk_idle_at_cs_rise", i, int'(sclk_w[i]), 0);
            got = pop_exp(i, w);
            chk("frame_expected", i, int'(got), 1);
            if (got) chk("frame_word", i, int'(word[i]), int'(w));
            if (i == 0) cap_log.push_back(word[i]);
            cs_rise[i] = cyc;
            in_fr[i]   = 1'b0;
            frames_done[i]++;
          end
        end
      end
      prev_cs[i]   = cs_w[i];
      prev_sclk[i] = sclk_w[i];
      prev_mosi[i] = mosi_w[i];
      prev_ldac[i] = ldac_w[i];
    end
  end

  task automatic send(input int idx, input logic [11:0] s, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (ready_w[idx] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", idx, int'(ready_w[idx]), 1);
    if (idx == 0) begin
      if_a.sample_in    = s;
      if_a.sample_valid = 1'b1;
      if (push) exp_q0.push_back({CMD_A, s});
    end else begin
      if_b.sample_in    = s;
      if_b.sample_valid = 1'b1;
      if (push) exp_q1.push_back({CMD_B, s});
    end
    $display("send inst%0d sample 0x%03h at cycle %0d", idx, s, cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int idx, input int n);
    int k;
    k = 0;
    while (frames_done[idx] < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("frames_done", idx, frames_done[idx], n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog inst0 got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          tv, dir, n;
    int          codes[16];
    logic [15:0] tmp;

    for (int i = 0; i < 2; i++) begin
      frames_started[i] = 0;
      frames_done[i]    = 0;
      cs_rise[i]        = 0;
      gap_last[i]       = 0;
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    if_a.sample_in = '0; if_a.sample_valid = 1'b0;
    if_b.sample_in = '0; if_b.sample_valid = 1'b0;

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_cs_n", i, int'(cs_w[i]), 1);
      chk("reset_sclk", i, int'(sclk_w[i]), 0);
      chk("reset_mosi", i, int'(mosi_w[i]), 0);
      chk("reset_ldac_n", i, int'(ldac_w[i]), 1);
      chk("reset_ready", i, int'(ready_w[i]), 1);
    end
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Single frame.
    send(0, 12'hA5C, 1'b1);
    if_a.sample_valid = 1'b0;
    wait_frames(0, 1);

    // Valid held high: back-to-back frames.
    send(0, 12'h000, 1'b1);
    send(0, 12'hFFF, 1'b1);
    if_a.sample_valid = 1'b0;
    wait_frames(0, 3);
    chk("cs_high_gap", 0, gap_last[0], 8);

    // Input churns every cycle while busy; only the accepted value goes out.
    send(0, 12'h3C1, 1'b1);
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if_a.sample_in = 12'($urandom);
    end
    if_a.sample_valid = 1'b0;
    wait_frames(0, 4);
    repeat (40) @(negedge clk);
    chk("accept_count", 0, frames_started[0], 4);

    // Reset after seven SCLK rising edges aborts the frame.
    send(0, 12'h5A5, 1'b0);
    if_a.sample_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (bits[0] < 7 && n < 200);
    chk("sclk_rises_before_reset", 0, bits[0], 7);
    rst_a = 1'b0;
    #1;
    chk("abort_cs_n", 0, int'(cs_a), 1);
    chk("abort_sclk", 0, int'(sclk_a), 0);
    chk("abort_ldac_n", 0, int'(ldac_a), 1);
    chk("abort_ready", 0, int'(if_a.sample_ready), 1);
    @(negedge clk);
    #2;
    rst_a = 1'b1;
    send(0, 12'h123, 1'b1);
    if_a.sample_valid = 1'b0;
    wait_frames(0, 5);

    // Fast instance: CLK_DIV=1, command 4'b0111.
    send(1, 12'h800, 1'b1);
    if_b.sample_valid = 1'b0;
    wait_frames(1, 1);

    // Triangle source around 100 with 8 codes peak-to-peak.
    tv  = 100;
    dir = 1;
    for (int k = 0; k < 16; k++) begin
      send(0, 12'(tv), 1'b1);
      if (tv == 104) dir = -1;
      if (tv == 96) dir = 1;
      tv = tv + dir;
    end
    if_a.sample_valid = 1'b0;
    wait_frames(0, 21);
    chk("tri_log_size", 0, cap_log.size(), 21);
    if (cap_log.size() >= 16) begin
      for (int k = 0; k < 16; k++) begin
        tmp      = cap_log[cap_log.size() - 16 + k];
        codes[k] = int'(tmp[11:0]);
        chk("tri_range", 0, int'(codes[k] >= 96 && codes[k] <= 104), 1);
      end
      for (int k = 1; k < 15; k++) begin
        if ((codes[k] - codes[k-1]) != (codes[k+1] - codes[k])) begin
          chk("tri_turning_point", 0, int'(codes[k] == 96 || codes[k] == 104), 1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
